// File: rtl/gpu_fill_circle_stream.sv
// +------------------------------------------------------------------------+
// | gpu_fill_circle_stream: clipped, de-duplicated filled-disc pixel stream |
// | with valid/ready output. Option: GPU_FILL_CIRCLE_COLOR_EN (colour pass) |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
`default_nettype none

module gpu_fill_circle_stream #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int CHANNEL_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH_BITS-1:0]   xC_i,
  input  logic [HEIGHT_BITS-1:0]  yC_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pix_valid_o,
  input  logic                    pix_ready_i,
  output logic [WIDTH_BITS-1:0]   X_o,
`ifdef GPU_FILL_CIRCLE_COLOR_EN
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
`endif
  output logic [HEIGHT_BITS-1:0]  Y_o
);

  localparam int CW = WIDTH_BITS + 2;
  localparam int SW = ((WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS) + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [1:0] C_A = 2'd0;
  localparam logic [1:0] C_B = 2'd1;
  localparam logic [1:0] C_C = 2'd2;
  localparam logic [1:0] C_D = 2'd3;

  localparam logic signed [SW-1:0] S_ZERO = '0;
  localparam logic signed [SW-1:0] X_MAX  = SW'(SCREEN_W - 1);
  localparam logic signed [SW-1:0] Y_MAX  = SW'(SCREEN_H - 1);
  localparam logic signed [CW-1:0] K_ZERO = '0;
  localparam logic signed [CW-1:0] K_ONE  = CW'(1);
  localparam logic signed [CW-1:0] K_3    = CW'(3);
  localparam logic signed [CW-1:0] K_5    = CW'(5);

  logic [1:0]              state;
  logic [1:0]              cand;
  logic [WIDTH_BITS-1:0]   xc;
  logic [HEIGHT_BITS-1:0]  yc;
  logic signed [CW-1:0]    x;
  logic signed [CW-1:0]    y;
  logic signed [CW-1:0]    f;
  logic [WIDTH_BITS-1:0]   rend;
  logic                    last_round;

  logic signed [SW-1:0]    xc_s, yc_s, x_s, y_s;
  logic signed [SW-1:0]    row, left, right, left_c, right_c;
  logic                    visible, app_b, app_cd, is_last;
  logic [1:0]              next_cand;
  logic signed [CW-1:0]    x_upd, y_upd, f_upd;
  logic                    cont;

  assign xc_s = SW'(xc);
  assign yc_s = SW'(yc);
  assign x_s  = SW'(x);
  assign y_s  = SW'(y);

  assign busy_o      = (state == S_SETUP) || (state == S_EMIT);
  assign done_o      = (state == S_FINISH);
  assign pix_valid_o = (state == S_EMIT);

  // B mirrors A unless it lands on the same row; C/D only when y is about to step.
  assign app_b  = (x != K_ZERO);
  assign app_cd = (f >= K_ZERO) && (x != y);

  always_comb begin
    row       = yc_s + x_s;
    left      = xc_s - y_s;
    right     = xc_s + y_s;
    is_last   = 1'b0;
    next_cand = C_A;
    case (cand)
      C_A: begin
        row       = yc_s + x_s;
        is_last   = !app_b && !app_cd;
        next_cand = app_b ? C_B : C_C;
      end
      C_B: begin
        row       = yc_s - x_s;
        is_last   = !app_cd;
        next_cand = C_C;
      end
      C_C: begin
        row       = yc_s + y_s;
        left      = xc_s - x_s;
        right     = xc_s + x_s;
        next_cand = C_D;
      end
      default: begin
        row       = yc_s - y_s;
        left      = xc_s - x_s;
        right     = xc_s + x_s;
        is_last   = 1'b1;
      end
    endcase
  end

  always_comb begin
    visible = (row >= S_ZERO) && (row <= Y_MAX) && (right >= S_ZERO) && (left <= X_MAX);
    left_c  = (left < S_ZERO) ? S_ZERO : left;
    right_c = (right > X_MAX) ? X_MAX : right;
  end

  always_comb begin
    if (f < K_ZERO) begin
      f_upd = f + (x <<< 1) + K_3;
      y_upd = y;
    end else begin
      f_upd = f + ((x - y) <<< 1) + K_5;
      y_upd = y - K_ONE;
    end
    x_upd = x + K_ONE;
    cont  = (x_upd <= y_upd);
  end

  // After clipping the high bits of these are always zero.
  logic unused_hi;
  assign unused_hi = ^{row[SW-1:HEIGHT_BITS], left_c[SW-1:WIDTH_BITS], right_c[SW-1:WIDTH_BITS]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cand       <= C_A;
      xc         <= '0;
      yc         <= '0;
      x          <= '0;
      y          <= '0;
      f          <= '0;
      rend       <= '0;
      last_round <= 1'b0;
      X_o        <= '0;
      Y_o        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            xc         <= xC_i;
            yc         <= yC_i;
            x          <= K_ZERO;
            y          <= CW'(rad_i);
            f          <= K_ONE - CW'(rad_i);
            cand       <= C_A;
            last_round <= 1'b0;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (visible) begin
            X_o   <= left_c[WIDTH_BITS-1:0];
            Y_o   <= row[HEIGHT_BITS-1:0];
            rend  <= right_c[WIDTH_BITS-1:0];
            state <= S_EMIT;
          end
          if (is_last) begin
            x          <= x_upd;
            y          <= y_upd;
            f          <= f_upd;
            cand       <= C_A;
            last_round <= !cont;
            if (!visible) state <= cont ? S_SETUP : S_FINISH;
          end else begin
            cand <= next_cand;
          end
        end
        S_EMIT: begin
          if (pix_ready_i) begin
            if (X_o == rend) state <= last_round ? S_FINISH : S_SETUP;
            else             X_o   <= X_o + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GPU_FILL_CIRCLE_COLOR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o <= '0;
      g_o <= '0;
      b_o <= '0;
    end else if (state == S_IDLE && start_i) begin
      r_o <= r_i;
      g_o <= g_i;
      b_o <= b_i;
    end
  end
`else
  logic [CHANNEL_BITS-1:0] unused_chan;
  assign unused_chan = '0;
`endif

endmodule

`default_nettype wire
